// File: rtl/sn_prot_pkg.sv
// rtl/sn_prot_pkg.sv - shared types and bus widths for the protocol-bus arbiter
// Contents: state_e (arbiter FSM states), ADDR_W / DATA_W (protocol bus widths).
package sn_prot_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

endpackage

// File: rtl/sn_rr_picker.sv
// rtl/sn_rr_picker.sv - combinational rotate-and-priority round-robin search
// Ports:
//   valid_i  per-requester request vector
//   ptr_i    index the search starts from (wraps past the top index)
//   gnt_o    one-hot winner, zero when nothing is valid
//   idx_o    binary index of the winner
//   any_o    at least one requester is valid
module sn_rr_picker #(
   parameter int P_NUM_REQ = 2,
   parameter int P_IDX_W   = 1
) (
   input  logic [P_NUM_REQ-1:0] valid_i,
   input  logic [P_IDX_W-1:0]   ptr_i,
   output logic [P_NUM_REQ-1:0] gnt_o,
   output logic [P_IDX_W-1:0]   idx_o,
   output logic                 any_o
);

   logic [P_IDX_W-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int i = 0; i < P_NUM_REQ; i++) begin
         cand = P_IDX_W'((int'(ptr_i) + i) % P_NUM_REQ);
         if (!any_o && valid_i[cand]) begin
            any_o       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/sn_prot_arbiter.sv
// rtl/sn_prot_arbiter.sv - round-robin arbiter with grant locking for a shared protocol register bus
// Optional feature macro: SN_PROT_ARB_LOCK_TIMEOUT_EN (bounds how long a locked grant may be held).
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   req_valid/r0w1/addr/wdata     per-requester transaction request
//   req_lock                      keep the grant after the current transaction
//   req_ready                     pulse in the cycle the transaction is issued
//   rsp_valid, rsp_rdata          response pulse to the owner, shared read data
//   prot_enable/r0w1/addr/wdata   protocol bus strobe and payload, all zero when idle
//   prot_rdata                    protocol bus read data, valid in the strobe cycle
//   arb_grant                     one-hot current owner
//   arb_timeout                   pulse on a forced lock release
module sn_prot_arbiter
   import sn_prot_pkg::*;
#(
   parameter int P_NUM_REQ      = 2,
   parameter int P_LOCK_TIMEOUT = 256
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [P_NUM_REQ-1:0]              req_valid,
   input  logic [P_NUM_REQ-1:0]              req_r0w1,
   input  logic [P_NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
   input  logic [P_NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
   input  logic [P_NUM_REQ-1:0]              req_lock,
   output logic [P_NUM_REQ-1:0]              req_ready,
   output logic [P_NUM_REQ-1:0]              rsp_valid,
   output logic [DATA_W-1:0]                 rsp_rdata,
   output logic                              prot_enable,
   output logic                              prot_r0w1,
   output logic [ADDR_W-1:0]                 prot_addr,
   output logic [DATA_W-1:0]                 prot_wdata,
   input  logic [DATA_W-1:0]                 prot_rdata,
   output logic [P_NUM_REQ-1:0]              arb_grant,
   output logic                              arb_timeout
);

   localparam int IDX_W = (P_NUM_REQ > 2) ? 2 : 1;

   if (P_NUM_REQ < 2 || P_NUM_REQ > 4 || P_LOCK_TIMEOUT < 1) begin : g_bad_param
      $error("sn_prot_arbiter: P_NUM_REQ must be 2..4 and P_LOCK_TIMEOUT at least 1");
   end

   state_e                state_q, state_d;
   logic [P_NUM_REQ-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
   logic [P_NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;

   logic [P_NUM_REQ-1:0]  pick_gnt;
   logic [IDX_W-1:0]      pick_idx;
   logic                  pick_any;
   logic                  sel_valid, sel_lock;
   logic                  strobe, release_now, force_rel;
   logic [IDX_W-1:0]      next_ptr;

   sn_rr_picker #(
      .P_NUM_REQ (P_NUM_REQ),
      .P_IDX_W   (IDX_W)
   ) u_picker (
      .valid_i (req_valid),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   assign sel_valid = req_valid[idx_q];
   assign sel_lock  = req_lock[idx_q];
   assign next_ptr  = (idx_q == IDX_W'(P_NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      idx_d       = idx_q;
      rr_ptr_d    = rr_ptr_q;
      rsp_rdata_d = rsp_rdata_q;
      strobe      = 1'b0;
      release_now = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d = pick_gnt;
               idx_d   = pick_idx;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (sel_valid) begin
               strobe      = 1'b1;
               rsp_rdata_d = req_r0w1[idx_q] ? '0 : prot_rdata;
               state_d     = ST_RESP;
            end else begin
               // Owner withdrew: give the bus back without touching the rotation.
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
         ST_RESP: begin
            if (!sel_lock || force_rel) begin
               release_now = 1'b1;
            end else if (sel_valid) begin
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!sel_lock || force_rel) begin
               release_now = 1'b1;
            end else if (sel_valid) begin
               state_d = ST_ISSUE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (release_now) begin
         state_d  = ST_IDLE;
         grant_d  = '0;
         rr_ptr_d = next_ptr;
      end
   end

   // Response pulse is registered out of RESP so it lands one cycle later.
   assign rsp_valid_d = (state_q == ST_RESP) ? grant_q : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         idx_q       <= '0;
         rr_ptr_q    <= '0;
         rsp_rdata_q <= '0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         idx_q       <= idx_d;
         rr_ptr_q    <= rr_ptr_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

`ifdef SN_PROT_ARB_LOCK_TIMEOUT_EN
   localparam int CNT_W = $clog2(P_LOCK_TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   // Counts from the grant's first ISSUE and saturates at the limit.
   assign force_rel = (cnt_q == CNT_W'(P_LOCK_TIMEOUT));
   assign timeout_d = release_now & sel_lock;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_IDLE) begin
         cnt_d = '0;
      end else if (!force_rel) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign arb_timeout = timeout_q;
`else
   assign force_rel   = 1'b0;
   assign arb_timeout = 1'b0;
`endif

   assign arb_grant   = grant_q;
   assign req_ready   = strobe ? grant_q : '0;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign prot_enable = strobe;
   assign prot_r0w1   = strobe & req_r0w1[idx_q];
   assign prot_addr   = strobe ? req_addr[idx_q] : '0;
   assign prot_wdata  = strobe ? req_wdata[idx_q] : '0;

endmodule

// File: tb/tb_sn_prot_arbiter.sv
// tb/tb_sn_prot_arbiter.sv - scoreboard bench for sn_prot_arbiter (two requesters)
module tb_sn_prot_arbiter;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_r0w1 = '0;
   logic [1:0][6:0] req_addr = '0;
   logic [1:0][7:0] req_wdata = '0;
   logic [1:0]      req_lock = '0;
   logic [1:0]      req_ready, rsp_valid, arb_grant;
   logic [7:0]      rsp_rdata, prot_wdata, prot_rdata;
   logic            prot_enable, prot_r0w1, arb_timeout;
   logic [6:0]      prot_addr;

   always #5 clk = ~clk;

   sn_prot_arbiter #(.P_NUM_REQ(2), .P_LOCK_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_r0w1(req_r0w1), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_lock(req_lock), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .prot_enable(prot_enable), .prot_r0w1(prot_r0w1), .prot_addr(prot_addr),
      .prot_wdata(prot_wdata), .prot_rdata(prot_rdata),
      .arb_grant(arb_grant), .arb_timeout(arb_timeout)
   );

   function automatic logic [7:0] rd_of(input logic [6:0] a);
      return 8'hA2 ^ {1'b0, a};
   endfunction

   assign prot_rdata = rd_of(prot_addr);

   typedef struct { logic r0w1; logic [6:0] addr; logic [7:0] wdata; logic lock; logic wd; } txn_t;
   typedef struct { int idx; logic r0w1; logic [6:0] addr; logic [7:0] wdata; int gap; } sexp_t;
   typedef struct { int idx; logic [7:0] data; } rexp_t;

   txn_t  tx_mem [2][32];
   int    tx_cnt [2];
   int    tx_head [2];
   logic  lock_r [2];
   sexp_t sq[$];
   rexp_t rq[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic load(input int i, input logic r0w1, input logic [6:0] a, input logic [7:0] d,
                       input logic lk, input logic wd);
      tx_mem[i][tx_cnt[i]] = '{r0w1: r0w1, addr: a, wdata: d, lock: lk, wd: wd};
      tx_cnt[i]++;
   endtask

   task automatic exp_s(input int i, input logic r0w1, input logic [6:0] a, input logic [7:0] d, input int gap);
      sq.push_back('{idx: i, r0w1: r0w1, addr: a, wdata: d, gap: gap});
   endtask

   task automatic exp_r(input int i, input logic [7:0] d);
      rq.push_back('{idx: i, data: d});
   endtask

   task automatic drain(input string nm);
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #3;
         if (sq.size() == 0 && rq.size() == 0) break;
      end
      chk(nm, sq.size() + rq.size(), 0);
      repeat (3) @(posedge clk);
      #3;
   endtask

   // Requester model: presents queued transactions, advances on req_ready.
   initial begin : driver
      logic [1:0] rdy_s;
      tx_cnt = '{0, 0};
      tx_head = '{0, 0};
      lock_r = '{1'b0, 1'b0};
      forever begin
         @(negedge clk);
         rdy_s = req_ready;
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (!rst) begin
               tx_head[i] = tx_cnt[i];
               lock_r[i]  = 1'b0;
            end else begin
               if (rdy_s[i] && tx_head[i] < tx_cnt[i]) begin
                  lock_r[i] = tx_mem[i][tx_head[i]].lock;
                  tx_head[i]++;
               end
               if (tx_head[i] < tx_cnt[i] && tx_mem[i][tx_head[i]].wd && arb_grant[i])
                  tx_head[i]++;
            end
            if (tx_head[i] < tx_cnt[i]) begin
               req_valid[i] = 1'b1;
               req_r0w1[i]  = tx_mem[i][tx_head[i]].r0w1;
               req_addr[i]  = tx_mem[i][tx_head[i]].addr;
               req_wdata[i] = tx_mem[i][tx_head[i]].wdata;
            end else begin
               req_valid[i] = 1'b0;
               req_r0w1[i]  = 1'b0;
               req_addr[i]  = '0;
               req_wdata[i] = '0;
            end
            req_lock[i] = lock_r[i];
         end
      end
   end

   // Monitor: pops expectations whenever the DUT strobes the bus or responds.
   initial begin : monitor
      sexp_t se;
      rexp_t re;
      int    last_strobe = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (prot_enable) begin
               chk("strobe_expected", sq.size() > 0, 1);
               if (sq.size() > 0) begin
                  se = sq.pop_front();
                  chk("strobe_ready", req_ready, 32'd1 << se.idx);
                  chk("strobe_grant", arb_grant, 32'd1 << se.idx);
                  chk("strobe_bus", {prot_r0w1, prot_addr, prot_wdata}, {se.r0w1, se.addr, se.wdata});
                  if (se.gap > 0) chk("strobe_gap", cyc - last_strobe, se.gap);
               end
               last_strobe = cyc;
            end else begin
               chk("bus_idle_zero", {prot_r0w1, prot_addr, prot_wdata, req_ready}, 0);
            end
            if (rsp_valid != 2'b00) begin
               chk("rsp_expected", rq.size() > 0, 1);
               if (rq.size() > 0) begin
                  re = rq.pop_front();
                  chk("rsp_owner", rsp_valid, 32'd1 << re.idx);
                  chk("rsp_data", rsp_rdata, re.data);
               end
            end
         end
      end
   end

   initial begin : main
      int n0, got, bad, seen;
      repeat (3) @(negedge clk);
      chk("reset_grant", arb_grant, 0);
      chk("reset_bus", {prot_enable, prot_r0w1, prot_addr, prot_wdata}, 0);
      chk("reset_rsp", {rsp_valid, rsp_rdata, req_ready, arb_timeout}, 0);
      @(posedge clk); #4;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #3;

      // simultaneous from reset: 0 then 1
      exp_s(0, 0, 7'h10, 8'h5A, 0); exp_s(1, 0, 7'h20, 8'h5B, 0);
      exp_r(0, rd_of(7'h10));       exp_r(1, rd_of(7'h20));
      load(0, 0, 7'h10, 8'h5A, 0, 0); load(1, 0, 7'h20, 8'h5B, 0, 0);
      drain("drain_simul");

      // req0 alone leaves rr_ptr=1, so the next tie goes to req1
      exp_s(0, 0, 7'h30, 8'h00, 0); exp_r(0, rd_of(7'h30));
      load(0, 0, 7'h30, 8'h00, 0, 0);
      drain("drain_solo0");
      exp_s(1, 0, 7'h32, 8'h02, 0); exp_s(0, 0, 7'h31, 8'h01, 0);
      exp_r(1, rd_of(7'h32));       exp_r(0, rd_of(7'h31));
      load(0, 0, 7'h31, 8'h01, 0, 0); load(1, 0, 7'h32, 8'h02, 0, 0);
      drain("drain_rr1");

      // read latency, req1 addr 0x05
      exp_s(1, 0, 7'h05, 8'h00, 0); exp_r(1, 8'hA7);
      load(1, 0, 7'h05, 8'h00, 0, 0);
      n0 = -1; got = -100;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (req_valid[1] && n0 < 0) n0 = cyc;
         if (rsp_valid[1]) begin got = cyc; break; end
      end
      chk("rsp_latency", got - n0, 3);
      drain("drain_latency");

      // req0 locked burst of 4 writes with req1 waiting
      for (int k = 0; k < 4; k++)
         exp_s(0, 1, 7'(7'h40 + k), 8'(8'h11 * (k + 1)), (k == 0) ? 0 : 2);
      exp_s(1, 0, 7'h50, 8'h00, 3);
      for (int k = 0; k < 4; k++) exp_r(0, 8'h00);
      exp_r(1, rd_of(7'h50));
      for (int k = 0; k < 4; k++)
         load(0, 1, 7'(7'h40 + k), 8'(8'h11 * (k + 1)), (k < 3) ? 1'b1 : 1'b0, 0);
      load(1, 0, 7'h50, 8'h00, 0, 0);
      drain("drain_lock_burst");

      // withdrawal by req1 with rr_ptr=1
      exp_s(0, 0, 7'h60, 8'h00, 0); exp_r(0, rd_of(7'h60));
      load(0, 0, 7'h60, 8'h00, 0, 0);
      drain("drain_pre_wd");
      load(1, 0, 7'h61, 8'h00, 0, 1);
      bad = 0; seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (arb_grant[1]) seen = 1;
         if (prot_enable || rsp_valid != 2'b00) bad++;
      end
      chk("withdraw_grant_seen", seen, 1);
      chk("withdraw_no_activity", bad, 0);
      chk("withdraw_idle", arb_grant, 0);
      @(posedge clk); #3;
      exp_s(1, 0, 7'h62, 8'h00, 0); exp_s(0, 0, 7'h44, 8'h00, 0);
      exp_r(1, rd_of(7'h62));       exp_r(0, rd_of(7'h44));
      load(0, 0, 7'h44, 8'h00, 0, 0); load(1, 0, 7'h62, 8'h00, 0, 0);
      drain("drain_post_wd");

      // asynchronous reset in the middle of an ISSUE
      load(1, 0, 7'h33, 8'h00, 0, 0);
      got = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #2;
         if (arb_grant[1]) begin got = 1; break; end
      end
      chk("rst_pre_grant", got, 1);
      chk("rst_pre_strobe", prot_enable, 1);
      chk("rst_pre_rdata", rsp_rdata, 8'hE6);
      rst = 1'b0;
      #1;
      chk("rst_async_grant", arb_grant, 0);
      chk("rst_async_bus", {prot_enable, prot_r0w1, prot_addr, prot_wdata, req_ready}, 0);
      chk("rst_async_rsp", {rsp_valid, rsp_rdata, arb_timeout}, 0);
      repeat (2) @(posedge clk);
      #4;
      rst = 1'b1;
      @(posedge clk); #3;
      exp_s(0, 0, 7'h11, 8'h00, 0); exp_s(1, 0, 7'h22, 8'h00, 0);
      exp_r(0, rd_of(7'h11));       exp_r(1, rd_of(7'h22));
      load(0, 0, 7'h11, 8'h00, 0, 0); load(1, 0, 7'h22, 8'h00, 0, 0);
      drain("drain_post_rst");

      // req0 keeps its lock with no further traffic
      exp_s(0, 0, 7'h70, 8'h00, 0); exp_r(0, rd_of(7'h70));
      load(0, 0, 7'h70, 8'h00, 1, 0);
      drain("drain_hold");
`ifdef SN_PROT_ARB_LOCK_TIMEOUT_EN
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (arb_timeout) seen++;
      end
      chk("timeout_pulses", seen, 1);
      chk("timeout_released", arb_grant, 0);
`else
      bad = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (arb_grant !== 2'b01 || arb_timeout) bad++;
      end
      chk("lock_persist", bad, 0);
`endif
      @(posedge clk); #3;
      exp_s(0, 1, 7'h7F, 8'hC3, 0); exp_r(0, 8'h00);
      load(0, 1, 7'h7F, 8'hC3, 0, 0);
      drain("drain_unlock");
      chk("final_idle", arb_grant, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
